// File: rtl/vga_tile_renderer_if.sv
// Pixel-coordinate/entity request bundle from the VGA timing side and the colour result back to the DAC.
// The timing counter is the master; the renderer is the slave.
interface vga_tile_renderer_if #(
   parameter int ENT_W = 2
) ();
   logic [9:0]       iVGA_X;
   logic [9:0]       iVGA_Y;
   logic [ENT_W-1:0] iEnt;
   logic [1:0]       iMode;
   logic [15:0]      oRGB;
   logic             oValid;
   logic             oFrameStart;

   modport master (
      output iVGA_X, iVGA_Y, iEnt, iMode,
      input  oRGB, oValid, oFrameStart
   );

   modport slave (
      input  iVGA_X, iVGA_Y, iEnt, iMode,
      output oRGB, oValid, oFrameStart
   );
endinterface

// File: rtl/vga_tile_renderer.sv
// Maps (X, Y, entity) to an RGB565 pixel from tiled sprite ROMs + palette or a built-in test pattern.
// Fixed 2-cycle latency in every mode; no backpressure, one pixel accepted every clock.
module vga_tile_renderer #(
   parameter int          H_ACTIVE     = 640,
   parameter int          V_ACTIVE     = 480,
   parameter int          TILE_LOG2    = 4,
   parameter int          NUM_ENT      = 4,
   parameter int          ENT_W        = 2,
   parameter int          ENT_NOTHING  = 0,
   parameter int          PIX_W        = 3,
   parameter logic [15:0] BG_COLOR     = 16'hFFFF,
   parameter logic [NUM_ENT-1:0] BLINK_MASK = '0,
   parameter int          BLINK_LOG2   = 5,
   parameter string       SPRITE_FILE  = "sprites.hex",
   parameter string       PALETTE_FILE = "palette.hex",
   parameter logic [(2**ENT_W)*(2**(2*TILE_LOG2))*PIX_W-1:0] SPRITE_INIT  = '0,
   parameter logic [(2**PIX_W)*16-1:0]                       PALETTE_INIT = '0
) (
   input logic                iVGA_CLK,
   input logic                reset,
   vga_tile_renderer_if.slave vga
);

   localparam int ADDR_W    = ENT_W + 2*TILE_LOG2;
   localparam int ROM_DEPTH = 2**ADDR_W;
   localparam int PAL_DEPTH = 2**PIX_W;
   localparam int BAND_H    = V_ACTIVE / 8;
   localparam int FCNT_W    = BLINK_LOG2 + 1;
   localparam int EXT_W     = 2**ENT_W;
   localparam logic [EXT_W-1:0] BLINK_EXT = EXT_W'(BLINK_MASK);

   typedef enum logic [1:0] {
      MODE_GAME  = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_SOLID = 2'd3
   } mode_t;

   logic [PIX_W-1:0] spriteMem  [ROM_DEPTH];
   logic [15:0]      paletteMem [PAL_DEPTH];

   // Parameter images initialise the sprite ROM and palette.
   initial begin
      for (int i = 0; i < ROM_DEPTH; i++) spriteMem[i] = SPRITE_INIT[i*PIX_W +: PIX_W];
      for (int i = 0; i < PAL_DEPTH; i++) paletteMem[i] = PALETTE_INIT[i*16 +: 16];
   end

   logic              prevOrigin;
   mode_t             modeLatch;
   logic [FCNT_W-1:0] frameCnt;

   logic              origin, fs, active, empty, entOor;
   mode_t             effMode;
   logic [FCNT_W-1:0] effFrame;
   logic [ADDR_W-1:0] romAddr;
   logic [9:0]        band;
   logic [15:0]       patColor;

   logic              active1, empty1, game1, fs1;
   logic [15:0]       pat1;
   logic [PIX_W-1:0]  pixIdx1;

   // The frame-start pixel already belongs to the new frame, so it sees the new mode and blink phase.
   always_comb begin
      origin   = (vga.iVGA_X == 10'd0) && (vga.iVGA_Y == 10'd0);
      fs       = origin && !prevOrigin;
      effMode  = fs ? mode_t'(vga.iMode) : modeLatch;
      effFrame = fs ? frameCnt + 1'b1 : frameCnt;
      active   = (int'(vga.iVGA_X) < H_ACTIVE) && (int'(vga.iVGA_Y) < V_ACTIVE);
      entOor   = int'(vga.iEnt) >= NUM_ENT;
      empty    = (vga.iEnt == ENT_W'(ENT_NOTHING)) || entOor ||
                 (BLINK_EXT[vga.iEnt] && effFrame[BLINK_LOG2]);
      romAddr  = {vga.iEnt, vga.iVGA_Y[TILE_LOG2-1:0], vga.iVGA_X[TILE_LOG2-1:0]};
      band     = vga.iVGA_Y / 10'(BAND_H);
      patColor = BG_COLOR;
      case (effMode)
         MODE_BARS: begin
            if (band > 10'd7) patColor = 16'h0000;
            else patColor = {{5{~band[2]}}, {6{~band[0]}}, {5{~band[1]}}};
         end
         MODE_CHECK: begin
            if (vga.iVGA_X[TILE_LOG2] ^ vga.iVGA_Y[TILE_LOG2]) patColor = 16'h0000;
         end
         default: patColor = BG_COLOR;
      endcase
   end

   // Stage 1: the ROM output register doubles as the registered sprite address.
   always_ff @(posedge iVGA_CLK or posedge reset) begin
      if (reset) begin
         prevOrigin <= 1'b1;
         modeLatch  <= MODE_GAME;
         frameCnt   <= '0;
         active1    <= 1'b0;
         empty1     <= 1'b0;
         game1      <= 1'b0;
         fs1        <= 1'b0;
         pat1       <= 16'h0000;
         pixIdx1    <= '0;
      end else begin
         prevOrigin <= origin;
         if (fs) begin
            modeLatch <= effMode;
            frameCnt  <= effFrame;
         end
         active1 <= active;
         empty1  <= empty;
         game1   <= (effMode == MODE_GAME);
         fs1     <= fs;
         pat1    <= patColor;
         pixIdx1 <= (active && !empty) ? spriteMem[romAddr] : '0;
      end
   end

   // Stage 2: palette lookup and output register.
   always_ff @(posedge iVGA_CLK or posedge reset) begin
      if (reset) begin
         vga.oRGB        <= 16'h0000;
         vga.oValid      <= 1'b0;
         vga.oFrameStart <= 1'b0;
      end else begin
         vga.oValid      <= active1;
         vga.oFrameStart <= fs1;
         if (!active1)                        vga.oRGB <= 16'h0000;
         else if (!game1)                     vga.oRGB <= pat1;
         else if (empty1 || pixIdx1 == '0)    vga.oRGB <= BG_COLOR;
         else                                 vga.oRGB <= paletteMem[pixIdx1];
      end
   end

endmodule
